dmd_frame_renderer: RTL and testbench

- Parametrised successor to the single-bank DMD screen generator.
- Holds a double-buffered BPP-bit-per-dot frame store (front/back banks) and accepts host writes into the back bank.
- Swaps banks on request at the next frame boundary.
- Converts each dot to tinted 8-bit RGB for the LCD timing path, with fixed 2-cycle latency.

---
 rtl/dmd_frame_renderer.sv | 184 ++++++++++++++++++
 tb/tb_dmd_frame_renderer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmd_frame_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : dmd_frame_renderer
//  Description : Double-buffered BPP-bit-per-dot DMD frame store with tinted
//                8-bit RGB output for the LCD timing path. The host writes into
//                the back bank. A swap request is committed at the next frame
//                start. Pixel output has a fixed 2-cycle latency from i_x/i_y.
//  Ports       : clk, rst (sync, active high)
//                i_x/i_y/i_de/i_frame_start  - video timing inputs
//                i_wr_en/i_wr_addr/i_wr_data - back-bank write port
//                i_swap_req/o_swap_ack       - bank swap handshake
//                i_tint_r/g/b                - per-channel colour scale
//                o_r/o_g/o_b/o_de            - pixel output
//                i_test                      - only with DMD_TEST_PATTERN_EN
//  Options     : `define DMD_TEST_PATTERN_EN adds an x^y test-pattern source
//  Revision    : 1.0 - initial release
// ============================================================================
module dmd_frame_renderer #(
    parameter int DMD_W    = 128,
    parameter int DMD_H    = 32,
    parameter int X_W      = 8,
    parameter int Y_W      = 6,
    parameter int BPP      = 4,
    parameter int BG_LEVEL = 50,
    localparam int DEPTH   = DMD_W * DMD_H,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [X_W-1:0]    i_x,
    input  logic [Y_W-1:0]    i_y,
    input  logic              i_de,
    input  logic              i_frame_start,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [BPP-1:0]    i_wr_data,
    input  logic              i_swap_req,
    output logic              o_swap_ack,
`ifdef DMD_TEST_PATTERN_EN
    input  logic              i_test,
`endif
    input  logic [7:0]        i_tint_r,
    input  logic [7:0]        i_tint_g,
    input  logic [7:0]        i_tint_b,
    output logic [7:0]        o_r,
    output logic [7:0]        o_g,
    output logic [7:0]        o_b,
    output logic              o_de
);

    localparam int          STEP    = (255 - BG_LEVEL) / ((1 << BPP) - 1);
    localparam logic [31:0] W_U     = 32'(DMD_W);
    localparam logic [31:0] H_U     = 32'(DMD_H);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    // ------------------------------------------------------------------
    // Swap handshake FSM. S_ACK is the single cycle after a commit; the
    // request line is ignored there so the host has one cycle to drop it.
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;
    logic       w_commit;
    logic       front_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_swap_req) state_d = i_frame_start ? S_ACK : S_PEND;
            S_PEND:  if (i_frame_start) state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_commit   = (state_d == S_ACK) && (state_q != S_ACK);
        o_swap_ack = (state_q == S_ACK);
    end

    always_ff @(posedge clk) begin
        if (rst)           front_q <= 1'b0;
        else if (w_commit) front_q <= ~front_q;
    end

    // ------------------------------------------------------------------
    // Frame store. Writes always go to the bank that is not being shown,
    // using the pre-commit front, so a write in the commit cycle lands in
    // the bank that becomes visible.
    // ------------------------------------------------------------------
    logic [BPP-1:0]    bank0_mem [DEPTH];
    logic [BPP-1:0]    bank1_mem [DEPTH];
    logic              w_wr_ok;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_raddr;
    logic [BPP-1:0]    rd_q;

    assign w_wr_ok    = i_wr_en && (32'(i_wr_addr) < DEPTH_U);
    assign w_in_range = (32'(i_x) < W_U) && (32'(i_y) < H_U);
    // Out-of-range coordinates read address 0; the result is masked later.
    assign w_raddr    = w_in_range ? ADDR_W'(32'(i_y) * W_U + 32'(i_x)) : '0;

    always_ff @(posedge clk) begin
        if (w_wr_ok && front_q)  bank0_mem[i_wr_addr] <= i_wr_data;
        if (w_wr_ok && !front_q) bank1_mem[i_wr_addr] <= i_wr_data;
        rd_q <= front_q ? bank1_mem[w_raddr] : bank0_mem[w_raddr];
    end

    // ------------------------------------------------------------------
    // Stage 1 control: de/in_range travel alongside the RAM read.
    // ------------------------------------------------------------------
    logic           de1_q;
    logic           inr1_q;
    logic [BPP-1:0] w_pix1;

`ifdef DMD_TEST_PATTERN_EN
    logic           test1_q;
    logic [BPP-1:0] tp1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            test1_q <= 1'b0;
            tp1_q   <= '0;
        end else begin
            test1_q <= i_test;
            tp1_q   <= BPP'(32'(i_x) ^ 32'(i_y));
        end
    end

    assign w_pix1 = test1_q ? tp1_q : rd_q;
`else
    assign w_pix1 = rd_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            de1_q  <= 1'b0;
            inr1_q <= 1'b0;
        end else begin
            de1_q  <= i_de;
            inr1_q <= w_in_range;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: intensity ramp and tint. Multiplying by (tint+1) and keeping
    // the upper byte makes tint=255 an exact pass-through.
    // ------------------------------------------------------------------
    function automatic logic [7:0] scale(input logic [7:0] inten,
                                         input logic [7:0] tint);
        logic [15:0] prod;
        prod  = {8'd0, inten} * ({8'd0, tint} + 16'd1);
        scale = 8'(prod >> 8);
    endfunction

    logic [7:0] w_inten;
    logic       w_vld1;

    assign w_inten = 8'(BG_LEVEL) + 8'(w_pix1) * 8'(STEP);
    assign w_vld1  = de1_q && inr1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_de <= 1'b0;
            o_r  <= 8'd0;
            o_g  <= 8'd0;
            o_b  <= 8'd0;
        end else begin
            o_de <= w_vld1;
            o_r  <= w_vld1 ? scale(w_inten, i_tint_r) : 8'd0;
            o_g  <= w_vld1 ? scale(w_inten, i_tint_g) : 8'd0;
            o_b  <= w_vld1 ? scale(w_inten, i_tint_b) : 8'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmd_frame_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmd_frame_renderer
//  Description : Directed scoreboard testbench for dmd_frame_renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmd_frame_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  x;
    logic [5:0]  y;
    logic        de, fs, wen, req, ack, tst;
    logic [11:0] waddr;
    logic [3:0]  wdata;
    logic [7:0]  tr, tg, tb_b;
    logic [7:0]  o_r, o_g, o_b;
    logic        o_de;

    always #5 clk = ~clk;

    dmd_frame_renderer dut (
        .clk           (clk),
        .rst           (rst),
        .i_x           (x),
        .i_y           (y),
        .i_de          (de),
        .i_frame_start (fs),
        .i_wr_en       (wen),
        .i_wr_addr     (waddr),
        .i_wr_data     (wdata),
        .i_swap_req    (req),
        .o_swap_ack    (ack),
`ifdef DMD_TEST_PATTERN_EN
        .i_test        (tst),
`endif
        .i_tint_r      (tr),
        .i_tint_g      (tg),
        .i_tint_b      (tb_b),
        .o_r           (o_r),
        .o_g           (o_g),
        .o_b           (o_b),
        .o_de          (o_de)
    );

    typedef struct {
        logic       de;
        logic [7:0] r, g, b;
    } ent_t;

    localparam int STEP = (255 - 50) / 15;

    ent_t q[$];
    int   mb0[4096];
    int   mb1[4096];
    bit   m_front, m_pend, m_ackcyc;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] scale(input int inten, input int tint);
        return 8'((inten * (tint + 1)) >> 8);
    endfunction

    function automatic ent_t model_out();
        ent_t e;
        int   pix, a, inten;
        e.de = 1'b0; e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
        if (de && int'(x) < 128 && int'(y) < 32) begin
            a     = int'(y) * 128 + int'(x);
            pix   = m_front ? mb1[a] : mb0[a];
            if (tst) pix = int'(x ^ {2'b00, y}) & 15;
            inten = 50 + pix * STEP;
            e.de  = 1'b1;
            e.r   = scale(inten, int'(tr));
            e.g   = scale(inten, int'(tg));
            e.b   = scale(inten, int'(tb_b));
        end
        return e;
    endfunction

    // One clock of stimulus: push expectation, update model, clock, compare.
    task automatic cyc();
        ent_t e, o;
        bit   commit;
        e = model_out();
        q.push_back(e);
        if (wen) begin
            if (m_front) mb0[int'(waddr)] = int'(wdata);
            else         mb1[int'(waddr)] = int'(wdata);
        end
        commit = fs && (m_pend || req) && !m_ackcyc;
        if (commit) begin
            m_front  = !m_front;
            m_pend   = 1'b0;
            m_ackcyc = 1'b1;
        end else if (m_ackcyc) begin
            m_ackcyc = 1'b0;
            m_pend   = 1'b0;
        end else begin
            m_pend = m_pend | req;
        end
        @(posedge clk); #1;
        chk("swap_ack", {7'd0, ack}, {7'd0, m_ackcyc});
        if (q.size() >= 2) begin
            o = q.pop_front();
            chk("o_de", {7'd0, o_de}, {7'd0, o.de});
            chk("o_r", o_r, o.r);
            chk("o_g", o_g, o.g);
            chk("o_b", o_b, o.b);
        end
        de = 1'b0; fs = 1'b0; req = 1'b0; wen = 1'b0; tst = 1'b0;
    endtask

    task automatic do_reset();
        ent_t z;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        z.de = 1'b0; z.r = 8'd0; z.g = 8'd0; z.b = 8'd0;
        q.push_back(z);
        m_front = 1'b0; m_pend = 1'b0; m_ackcyc = 1'b0;
        chk("rst_de", {7'd0, o_de}, 8'd0);
        chk("rst_r", o_r, 8'd0);
        chk("rst_g", o_g, 8'd0);
        chk("rst_b", o_b, 8'd0);
        chk("rst_ack", {7'd0, ack}, 8'd0);
    endtask

    task automatic set_tint(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        cyc();
        tr = r; tg = g; tb_b = b;
    endtask

    task automatic rd(input int xi, input int yi);
        x = 8'(xi); y = 6'(yi); de = 1'b1;
        cyc();
    endtask

    initial begin
        rst = 1'b1; x = 8'd0; y = 6'd0; de = 1'b0; fs = 1'b0; wen = 1'b0;
        req = 1'b0; tst = 1'b0; waddr = 12'd0; wdata = 4'd0;
        tr = 8'd255; tg = 8'd255; tb_b = 8'd255;
        do_reset();

        // Bank 1 = 0, make it the front, then bank 0 = 15.
        for (int a = 0; a < 4096; a++) begin
            wen = 1'b1; waddr = 12'(a); wdata = 4'd0; cyc();
        end
        req = 1'b1; fs = 1'b1; cyc();
        cyc();
        for (int a = 0; a < 4096; a++) begin
            wen = 1'b1; waddr = 12'(a); wdata = 4'd15; cyc();
        end
        rd(0, 0);                                  // unlit: 50
        req = 1'b1; cyc();
        fs = 1'b1; x = 8'd0; y = 6'd0; de = 1'b1; cyc();
        for (int yi = 0; yi < 32; yi++)
            for (int xi = 0; xi < 128; xi++)
                rd(xi, yi);                        // all 245

        // Single dot at (3,2)=8 with a colour tint.
        wen = 1'b1; waddr = 12'd259; wdata = 4'd8; cyc();
        req = 1'b1; fs = 1'b1; cyc();
        set_tint(8'd127, 8'd255, 8'd0);
        rd(3, 2);                                  // 77,154,0
        rd(4, 2);

        // Mid-frame requests wait for frame start; second request absorbed.
        req = 1'b1; cyc();
        cyc(); cyc();
        rd(3, 2);
        req = 1'b1; cyc();
        cyc();
        fs = 1'b1; cyc();
        cyc(); cyc();
        rd(3, 2);                                  // front back to bank 0
        fs = 1'b1; cyc();                          // no pending: no effect
        rd(3, 2);

        // Out of range / idle dots.
        rd(128, 5);
        rd(0, 32);
        x = 8'd3; y = 6'd2; de = 1'b0; cyc();

        // Write in the commit cycle lands in the newly shown bank.
        req = 1'b1; cyc();
        wen = 1'b1; waddr = 12'd0; wdata = 4'd7; fs = 1'b1;
        x = 8'd0; y = 6'd0; de = 1'b1; cyc();
        rd(0, 0);                                  // 70,141,0
        // Same-address read and write in one cycle.
        wen = 1'b1; waddr = 12'd259; wdata = 4'd3; x = 8'd3; y = 6'd2; de = 1'b1; cyc();
        rd(3, 2);

`ifdef DMD_TEST_PATTERN_EN
        set_tint(8'd255, 8'd255, 8'd255);
        tst = 1'b1; x = 8'd5; y = 6'd3; de = 1'b1; cyc();   // 128
        cyc();
`endif

        // Reset mid-frame with a pending swap.
        set_tint(8'd255, 8'd255, 8'd255);
        req = 1'b1; cyc();
        x = 8'd3; y = 6'd2; de = 1'b1;
        do_reset();
        de = 1'b1; cyc();
        fs = 1'b1; cyc();
        rd(3, 2);                                  // bank 0 dot = 3 -> 89
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
